click_decoder: RTL and testbench
================================

CLICK_DECODER -- requirements
Module: click_decoder

Interface
REQ-001 SHALL have parameter GAP_MAX, default 50000: maximum idle cycles between presses of one click sequence; legal range 2..65535.
REQ-002 SHALL have parameter CNT_W, default 16: gap timer width; GAP_MAX SHALL fit in CNT_W bits.
REQ-003 SHALL have port clk_i, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_i, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port press_i, input, 1: one-cycle debounced press pulse; high = one press.
REQ-006 SHALL have port single_o, output, 1: one-cycle pulse when a sequence closes with 1 press.
REQ-007 SHALL have port double_o, output, 1: one-cycle pulse when a sequence closes with 2 presses.
REQ-008 SHALL have port triple_o, output, 1: one-cycle pulse on the 3rd press of a sequence.
REQ-009 SHALL have port busy_o, output, 1: high whenever the state is not IDLE.
REQ-010 SHALL have port count_o, output, 2: number of presses accepted in the open sequence (0..2).

Function
REQ-011 SHALL implement states IDLE, WAIT1, WAIT2, LOCKOUT (LOCKOUT reachable only per REQ-024).
REQ-012 SHALL register all outputs; each pulse output SHALL be high for exactly one cycle per event.
REQ-013 IDLE: press_i=1 at an edge -> WAIT1, timer=0, count_o=1.
REQ-014 WAIT1: press_i=1 -> WAIT2, timer=0, count_o=2.
REQ-015 WAIT2: press_i=1 -> triple_o=1 in the following cycle, count_o=0, next state per REQ-024/025.
REQ-016 WAIT1/WAIT2 without press: timer increments by 1 per cycle.
REQ-017 WAIT1 with timer==GAP_MAX-1 and press_i=0 -> IDLE, single_o=1, count_o=0, timer=0.
REQ-018 WAIT2 with timer==GAP_MAX-1 and press_i=0 -> IDLE, double_o=1, count_o=0, timer=0.
REQ-019 Latency: single_o/double_o SHALL rise exactly GAP_MAX cycles after the edge sampling the last press; triple_o exactly 1 cycle after the edge sampling the 3rd press.
REQ-020 Simultaneous press_i=1 and timer==GAP_MAX-1: the press SHALL win (advance state, clear timer); no single_o/double_o.
REQ-021 Timer SHALL never exceed GAP_MAX-1 and SHALL never wrap.
REQ-022 At most one of single_o, double_o, triple_o SHALL be high in any cycle.
REQ-023 press_i high for multiple consecutive cycles SHALL count as one press per cycle high.

Reset
REQ-026 reset_i=0 SHALL immediately, independent of clk_i, force state=IDLE, timer=0, count_o=0, single_o=double_o=triple_o=busy_o=0.
REQ-027 Reset asserted mid-sequence SHALL discard the sequence; no pulse SHALL emerge after release.
REQ-028 First press sampled on the first rising edge after reset_i returns high SHALL be accepted.

Configuration
REQ-024 With macro CLICK_LOCKOUT_EN defined: after a triple, state SHALL be LOCKOUT for GAP_MAX cycles, ignoring press_i, busy_o=1, then IDLE.
REQ-025 Without CLICK_LOCKOUT_EN: after a triple, state SHALL return to IDLE directly; a press in the next cycle SHALL start a new sequence; LOCKOUT SHALL not exist in logic.

Verification (GAP_MAX=8, CNT_W=4)
REQ-029 One press at cycle 10 -> single_o high only at cycle 18; count_o=1 for cycles 11..18, then 0; busy_o low from cycle 19.
REQ-030 Presses at cycles 10 and 15 -> double_o high only at cycle 23; no single_o.
REQ-031 Presses at 10, 17, 24 (gap 7) -> triple_o high at cycle 25; no single_o/double_o.
REQ-032 Presses at 10 and 18 (second coincides with timeout edge) -> press wins: WAIT2, double_o at cycle 26, no single_o.
REQ-033 Press at 10, reset_i low at cycles 13..14 -> all outputs 0 from 13 onward; no pulse through cycle 40.
REQ-034 Triple ending at 24, press at 26: with CLICK_LOCKOUT_EN ignored, busy_o high through 32, no pulse; without it, single_o at cycle 34.

Source files
------------

// File: rtl/click_decoder.sv
// click_decoder: classifies press pulses into single/double/triple click events.
// Optional post-triple lockout window enabled by defining CLICK_LOCKOUT_EN.
`default_nettype none

module click_decoder #(
  parameter int unsigned GAP_MAX = 50000,
  parameter int unsigned CNT_W   = 16
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       press_i,
  output logic       single_o,
  output logic       double_o,
  output logic       triple_o,
  output logic       busy_o,
  output logic [1:0] count_o
);

`ifdef CLICK_LOCKOUT_EN
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT1   = 2'd1,
    WAIT2   = 2'd2,
    LOCKOUT = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT1 = 2'd1,
    WAIT2 = 2'd2
  } state_e;
`endif

  localparam logic [CNT_W-1:0] TMAX = CNT_W'(GAP_MAX - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             single_q, single_d;
  logic             double_q, double_d;
  logic             trip_q, trip_d;
  logic             triple_q;
  logic             busy_q;
  logic [1:0]       count_q;
  logic             timeout;

  assign timeout = (timer_q == TMAX);

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    cnt_d    = cnt_q;
    single_d = 1'b0;
    double_d = 1'b0;
    trip_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (press_i) begin
          state_d = WAIT1;
          timer_d = '0;
          cnt_d   = 2'd1;
        end
      end
      WAIT1: begin
        // A press on the timeout edge takes priority over closing the sequence.
        if (press_i) begin
          state_d = WAIT2;
          timer_d = '0;
          cnt_d   = 2'd2;
        end else if (timeout) begin
          state_d  = IDLE;
          timer_d  = '0;
          cnt_d    = 2'd0;
          single_d = 1'b1;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      WAIT2: begin
        if (press_i) begin
          timer_d = '0;
          cnt_d   = 2'd0;
          trip_d  = 1'b1;
`ifdef CLICK_LOCKOUT_EN
          state_d = LOCKOUT;
`else
          state_d = IDLE;
`endif
        end else if (timeout) begin
          state_d  = IDLE;
          timer_d  = '0;
          cnt_d    = 2'd0;
          double_d = 1'b1;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
`ifdef CLICK_LOCKOUT_EN
      LOCKOUT: begin
        if (timeout) begin
          state_d = IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
`endif
      default: begin
        state_d = IDLE;
        timer_d = '0;
        cnt_d   = 2'd0;
      end
    endcase
  end

  // count/busy/triple are presented one cycle after the state they describe.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      cnt_q    <= 2'd0;
      single_q <= 1'b0;
      double_q <= 1'b0;
      trip_q   <= 1'b0;
      triple_q <= 1'b0;
      busy_q   <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      cnt_q    <= cnt_d;
      single_q <= single_d;
      double_q <= double_d;
      trip_q   <= trip_d;
      triple_q <= trip_q;
      busy_q   <= (state_q != IDLE);
      count_q  <= cnt_q;
    end
  end

  assign single_o = single_q;
  assign double_o = double_q;
  assign triple_o = triple_q;
  assign busy_o   = busy_q;
  assign count_o  = count_q;

endmodule

`default_nettype wire

// File: tb/tb_click_decoder.sv
// Directed self-checking bench for click_decoder (GAP_MAX=8, CNT_W=4).
`default_nettype none

module tb_click_decoder;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       press_i;
  logic       single_o;
  logic       double_o;
  logic       triple_o;
  logic       busy_o;
  logic [1:0] count_o;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  click_decoder #(.GAP_MAX(8), .CNT_W(4)) dut (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .press_i  (press_i),
    .single_o (single_o),
    .double_o (double_o),
    .triple_o (triple_o),
    .busy_o   (busy_o),
    .count_o  (count_o)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_single"}, int'(single_o), 0);
    check({tag, "_double"}, int'(double_o), 0);
    check({tag, "_triple"}, int'(triple_o), 0);
    check({tag, "_busy"},   int'(busy_o),   0);
    check({tag, "_count"},  int'(count_o),  0);
  endtask

  // Edge numbering restarts at 1 on the first rising edge after release.
  task automatic do_reset();
    press_i = 1'b0;
    reset_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check_idle("reset");
    reset_i = 1'b1;
    cyc = 0;
  endtask

  task automatic step(input logic p);
    press_i = p;
    @(posedge clk_i);
    #1;
    press_i = 1'b0;
    cyc++;
  endtask

  function automatic int in_rng(input int v, input int lo, input int hi);
    return ((v >= lo) && (v <= hi)) ? 1 : 0;
  endfunction

  // Presses p1..p4 (0 = unused); expected pulse cycles (0 = none);
  // count_o==1 over [c1a,c1b]u[c1c,c1d], ==2 over [c2a,c2b]; busy over [ba,bb]u[bc,bd].
  task automatic run_seq(input string tag,
                         input int p1, input int p2, input int p3, input int p4,
                         input int s_at, input int d_at, input int t_at,
                         input int c1a, input int c1b, input int c1c, input int c1d,
                         input int c2a, input int c2b,
                         input int ba, input int bb, input int bc, input int bd,
                         input int last);
    int exp_cnt;
    do_reset();
    for (int n = 1; n <= last; n++) begin
      step(n == p1 || n == p2 || n == p3 || n == p4);
      exp_cnt = (in_rng(cyc, c1a, c1b) | in_rng(cyc, c1c, c1d)) ? 1 :
                (in_rng(cyc, c2a, c2b) ? 2 : 0);
      check({tag, "_single"}, int'(single_o), (cyc == s_at) ? 1 : 0);
      check({tag, "_double"}, int'(double_o), (cyc == d_at) ? 1 : 0);
      check({tag, "_triple"}, int'(triple_o), (cyc == t_at) ? 1 : 0);
      check({tag, "_count"},  int'(count_o),  exp_cnt);
      check({tag, "_busy"},   int'(busy_o),   in_rng(cyc, ba, bb) | in_rng(cyc, bc, bd));
    end
  endtask

  initial begin
    reset_i = 1'b0;
    press_i = 1'b0;

    // One press -> single after GAP_MAX cycles.
    run_seq("single", 10, 0, 0, 0, 18, 0, 0, 11, 18, 0, -1, 0, -1, 11, 18, 0, -1, 30);
    // Two presses -> double, timed from the second press.
    run_seq("double", 10, 15, 0, 0, 0, 23, 0, 11, 15, 0, -1, 16, 23, 11, 23, 0, -1, 32);
    // Three presses with gap 7 -> triple one cycle after the third press.
    run_seq("triple", 10, 17, 24, 0, 0, 0, 25, 11, 17, 0, -1, 18, 24, 11, 24, 0, -1, 40);
    // Second press on the timeout edge wins.
    run_seq("edge", 10, 18, 0, 0, 0, 26, 0, 11, 18, 0, -1, 19, 26, 11, 26, 0, -1, 36);
    // First edge after reset release accepts a press.
    run_seq("first", 1, 0, 0, 0, 9, 0, 0, 2, 9, 0, -1, 0, -1, 2, 9, 0, -1, 14);
    // Held press counts once per cycle.
    run_seq("held", 10, 11, 12, 0, 0, 0, 13, 11, 11, 0, -1, 12, 12, 11, 12, 0, -1, 24);
`ifdef CLICK_LOCKOUT_EN
    run_seq("post_trip", 10, 17, 24, 26, 0, 0, 25, 11, 17, 0, -1, 18, 24, 11, 32, 0, -1, 40);
`else
    run_seq("post_trip", 10, 17, 24, 26, 34, 0, 25, 11, 17, 27, 34, 18, 24, 11, 24, 27, 34, 40);
`endif

    // Reset mid-sequence clears outputs immediately and discards the sequence.
    do_reset();
    for (int n = 1; n <= 12; n++) step(n == 10);
    check("midrst_count_before", int'(count_o), 1);
    check("midrst_busy_before",  int'(busy_o),  1);
    reset_i = 1'b0;
    #1;
    check_idle("midrst_async");
    step(1'b0);
    step(1'b0);
    check_idle("midrst_held");
    reset_i = 1'b1;
    for (int n = 15; n <= 40; n++) begin
      step(1'b0);
      check_idle("midrst_after");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
